// File: rtl/adc_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : adc_scan_sequencer
// Description : Time-shares one ADC across NUM_CH phase-current channels.
//               A free-running scan-tick counter (SAMPLE_DIV cycles per tick)
//               launches a scan. The scan converts channels 0..NUM_CH-1 in
//               turn over a start/done handshake. Each captured sample goes
//               out as a one-cycle valid strobe tagged with its channel.
//               Sticky flags report scan overruns and per-conversion ADC
//               timeouts to the trip logic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk           in   1       system clock
//   reset         in   1       synchronous, active-high reset
//   enable        in   1       runs the scan-tick counter (0 forces it to 0)
//   err_clear     in   1       clears the sticky error flags
//   adc_done      in   1       conversion complete, qualifies adc_data
//   adc_data      in   DATA_W  conversion result
//   adc_start     out  1       one-cycle conversion request
//   adc_ch        out  2       ADC mux channel, stable from start until done
//   sample_valid  out  1       one-cycle strobe: sample_data/sample_ch valid
//   sample_data   out  DATA_W  captured sample
//   sample_ch     out  2       channel of sample_data
//   busy          out  1       scan in progress
//   overrun_err   out  1       sticky: scan tick arrived while busy
//   timeout_err   out  1       sticky: a conversion timed out
//==============================================================================
module adc_scan_sequencer #(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 3,
    parameter int SAMPLE_DIV = 1000,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              err_clear,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_start,
    output logic [1:0]        adc_ch,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    output logic [1:0]        sample_ch,
    output logic              busy,
    output logic              overrun_err,
    output logic              timeout_err
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    // The wait counter only has to reach TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]  c_div_last  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);
    localparam logic [1:0]        c_last_ch   = 2'(NUM_CH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    //--------------------------------------------------------------------------
    // Registers and wires
    //--------------------------------------------------------------------------
    logic [CNT_W-1:0]  r_tick_cnt;
    logic [1:0]        r_state;
    logic [1:0]        r_ch;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_adc_start;
    logic              r_sample_valid;
    logic [DATA_W-1:0] r_sample_data;
    logic [1:0]        r_sample_ch;
    logic              r_busy;
    logic              r_overrun_err;
    logic              r_timeout_err;

    logic w_tick;
    logic w_in_wait;
    logic w_wait_last;
    logic w_conv_exit;
    logic w_overrun_set;
    logic w_timeout_set;

    //--------------------------------------------------------------------------
    // Scan-tick counter
    //--------------------------------------------------------------------------
    // The tick is combinational on the terminal count so the scan launches on
    // the cycle right after it (adc_start at T+1).
    assign w_tick = enable && (r_tick_cnt == c_div_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (!enable) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_div_last) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Conversion exit conditions
    //--------------------------------------------------------------------------
    // A conversion leaves WAIT on adc_done or on its last allowed cycle.
    // When both happen together, done wins and no timeout is flagged.
    assign w_in_wait     = (r_state == c_st_wait);
    assign w_wait_last   = (r_wait_cnt == c_wait_last);
    assign w_conv_exit   = w_in_wait && (adc_done || w_wait_last);
    assign w_timeout_set = w_in_wait && !adc_done && w_wait_last;
    // A tick while a scan is running is dropped and reported.
    assign w_overrun_set = w_tick && (r_state != c_st_idle);

    //--------------------------------------------------------------------------
    // Scan state machine
    //--------------------------------------------------------------------------
    // adc_start and busy are registered alongside the state transitions, so
    // adc_start is high exactly in the START cycle and busy mirrors
    // (state != IDLE) without a decode on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_ch           <= 2'd0;
            r_wait_cnt     <= '0;
            r_adc_start    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_data  <= '0;
            r_sample_ch    <= 2'd0;
            r_busy         <= 1'b0;
        end else begin
            r_adc_start    <= 1'b0;
            r_sample_valid <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_tick) begin
                        r_ch        <= 2'd0;
                        r_state     <= c_st_start;
                        r_adc_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                c_st_start: begin
                    r_wait_cnt <= '0;
                    r_state    <= c_st_wait;
                end

                c_st_wait: begin
                    if (w_conv_exit) begin
                        // A timed-out conversion leaves sample_data untouched.
                        if (adc_done) begin
                            r_sample_data  <= adc_data;
                            r_sample_ch    <= r_ch;
                            r_sample_valid <= 1'b1;
                        end
                        if (r_ch < c_last_ch) begin
                            r_ch        <= r_ch + 2'd1;
                            r_state     <= c_st_start;
                            r_adc_start <= 1'b1;
                        end else begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Sticky error flags: a new event outranks a same-cycle clear.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun_err <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun_err <= 1'b1;
            end else if (err_clear) begin
                r_overrun_err <= 1'b0;
            end

            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end else if (err_clear) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign adc_start    = r_adc_start;
    assign adc_ch       = r_ch;
    assign sample_valid = r_sample_valid;
    assign sample_data  = r_sample_data;
    assign sample_ch    = r_sample_ch;
    assign busy         = r_busy;
    assign overrun_err  = r_overrun_err;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire
